mem_responder: RTL and testbench

//  Memory-side responder to the control unit's memory strobes (ReadEn/WriteEn).

---
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and mem_responder (slave).
// Parity signals exist only when MEM_PARITY_EN is defined.
interface mem_responder_if;
    logic       ReadEn;
    logic       WriteEn;
    logic [7:0] Adr;
    logic [7:0] WData;
    logic [7:0] RData;
    logic       RdValid;
    logic       WrDone;
    logic       Busy;
    logic       ReqErr;
`ifdef MEM_PARITY_EN
    logic       ParInj;
    logic       ParErr;
`endif

    modport master (
        output ReadEn, WriteEn, Adr, WData,
`ifdef MEM_PARITY_EN
        output ParInj,
        input  ParErr,
`endif
        input  RData, RdValid, WrDone, Busy, ReqErr
    );

    modport slave (
        input  ReadEn, WriteEn, Adr, WData,
`ifdef MEM_PARITY_EN
        input  ParInj,
        output ParErr,
`endif
        output RData, RdValid, WrDone, Busy, ReqErr
    );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder: one request at a time, WAIT_CYCLES wait states, pulsed response.
// Optional even-parity storage/check is enabled by defining MEM_PARITY_EN.
module mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic            Fclk,
    input logic            ResetBar,
    mem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   adr_q;
    logic [7:0]      wdata_q;
    logic            op_wr;
    logic            strobe;
    logic            commit;
    logic [7:0]      mem [DEPTH];
`ifdef MEM_PARITY_EN
    logic            par [DEPTH];
    logic            inj_q;
`endif

    assign strobe = bus.ReadEn | bus.WriteEn;
    assign commit = (state == WAIT) && (cnt == '0);

    // Storage has no reset; an async reset forces state to IDLE, so an aborted write never commits.
    always_ff @(posedge Fclk) begin
        if (commit && op_wr) begin
            mem[adr_q] <= wdata_q;
`ifdef MEM_PARITY_EN
            par[adr_q] <= (^wdata_q) ^ inj_q;
`endif
        end
    end

    always_ff @(posedge Fclk or negedge ResetBar) begin
        if (!ResetBar) begin
            state       <= IDLE;
            cnt         <= '0;
            adr_q       <= '0;
            wdata_q     <= '0;
            op_wr       <= 1'b0;
            bus.RData   <= '0;
            bus.RdValid <= 1'b0;
            bus.WrDone  <= 1'b0;
            bus.Busy    <= 1'b0;
            bus.ReqErr  <= 1'b0;
`ifdef MEM_PARITY_EN
            inj_q       <= 1'b0;
            bus.ParErr  <= 1'b0;
`endif
        end else begin
            bus.RdValid <= 1'b0;
            bus.WrDone  <= 1'b0;
`ifdef MEM_PARITY_EN
            bus.ParErr  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (strobe) begin
                        adr_q    <= bus.Adr[AW-1:0];
                        wdata_q  <= bus.WData;
                        op_wr    <= bus.WriteEn;
                        cnt      <= 4'(WAIT_CYCLES);
                        bus.Busy <= 1'b1;
                        state    <= WAIT;
`ifdef MEM_PARITY_EN
                        inj_q    <= bus.ParInj;
`endif
                        // Collision: write wins, read is dropped.
                        if (bus.ReadEn && bus.WriteEn) bus.ReqErr <= 1'b1;
                    end
                end
                WAIT: begin
                    if (strobe) bus.ReqErr <= 1'b1;
                    if (cnt == '0) begin
                        if (op_wr) begin
                            bus.WrDone <= 1'b1;
                        end else begin
                            bus.RData   <= mem[adr_q];
                            bus.RdValid <= 1'b1;
`ifdef MEM_PARITY_EN
                            bus.ParErr  <= par[adr_q] != (^mem[adr_q]);
`endif
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (strobe) bus.ReqErr <= 1'b1;
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of directed transactions plus hand-written
// sequences for overrun, reset abort, address wrap (DEPTH=16, WAIT_CYCLES=0) and parity.
module tb_mem_responder;
    logic       Fclk = 1'b0;
    logic       ResetBar = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] adr = '0;
    logic [7:0] wd = '0;
    logic       inj = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_responder_if b256 ();
    mem_responder_if b16 ();

    assign b256.ReadEn  = rd;
    assign b256.WriteEn = wr;
    assign b256.Adr     = adr;
    assign b256.WData   = wd;
    assign b16.ReadEn   = rd;
    assign b16.WriteEn  = wr;
    assign b16.Adr      = adr;
    assign b16.WData    = wd;
`ifdef MEM_PARITY_EN
    assign b256.ParInj  = inj;
    assign b16.ParInj   = inj;
`endif

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) dut (
        .Fclk     (Fclk),
        .ResetBar (ResetBar),
        .bus      (b256)
    );

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut16 (
        .Fclk     (Fclk),
        .ResetBar (ResetBar),
        .bus      (b16)
    );

    always #5 Fclk = ~Fclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction: strobe for one cycle, then wait (bounded) for the response pulse.
    // lat = edges from accept to pulse; idle = Busy|RdValid|WrDone one cycle after the pulse.
    task automatic txn(input logic rd_i, input logic wr_i, input logic [7:0] a,
                       input logic [7:0] d, input logic inj_i, input logic ovr, input logic sel,
                       output int lat, output logic rv, output logic wdn,
                       output logic [7:0] rdat, output logic err, output logic perr,
                       output logic idle);
        lat = -1; rv = 1'b0; wdn = 1'b0; rdat = '0; err = 1'b0; perr = 1'b0; idle = 1'b1;
        @(negedge Fclk);
        rd = rd_i; wr = wr_i; adr = a; wd = d; inj = inj_i;
        @(negedge Fclk);
        rd = ovr; wr = 1'b0; inj = 1'b0;
        if (ovr) adr = 8'h10;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Fclk);
            rd = 1'b0;
            if (sel ? (b16.RdValid | b16.WrDone) : (b256.RdValid | b256.WrDone)) begin
                lat  = k;
                rv   = sel ? b16.RdValid : b256.RdValid;
                wdn  = sel ? b16.WrDone  : b256.WrDone;
                rdat = sel ? b16.RData   : b256.RData;
                err  = sel ? b16.ReqErr  : b256.ReqErr;
`ifdef MEM_PARITY_EN
                perr = sel ? b16.ParErr  : b256.ParErr;
`endif
                break;
            end
        end
        if (lat > 0) begin
            @(negedge Fclk);
            idle = sel ? (b16.Busy | b16.RdValid | b16.WrDone)
                       : (b256.Busy | b256.RdValid | b256.WrDone);
        end
    endtask

    typedef struct {
        string      name;
        logic       rd;
        logic       wr;
        logic [7:0] adr;
        logic [7:0] wd;
        int         lat;
        logic       rv;
        logic       wdn;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int         lat;
        logic       rv, wdn, err, perr, idle;
        logic [7:0] rdat;

        vecs[0] = '{"wr_3c",   1'b0, 1'b1, 8'h3C, 8'hA5, 2, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{"rd_3c",   1'b1, 1'b0, 8'h3C, 8'h00, 2, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{"wr_20",   1'b0, 1'b1, 8'h20, 8'h11, 2, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[3] = '{"rd_20",   1'b1, 1'b0, 8'h20, 8'h00, 2, 1'b1, 1'b0, 8'h11, 1'b0};
        vecs[4] = '{"rd_3c_b", 1'b1, 1'b0, 8'h3C, 8'h00, 2, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[5] = '{"collide", 1'b1, 1'b1, 8'h10, 8'h5A, 2, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[6] = '{"rd_10",   1'b1, 1'b0, 8'h10, 8'h00, 2, 1'b1, 1'b0, 8'h5A, 1'b1};

        repeat (3) @(negedge Fclk);
        chk("rst_rdata",  {24'h0, b256.RData}, 32'h00);
        chk("rst_rdval",  {31'h0, b256.RdValid}, 32'h0);
        chk("rst_wrdone", {31'h0, b256.WrDone}, 32'h0);
        chk("rst_busy",   {31'h0, b256.Busy}, 32'h0);
        chk("rst_reqerr", {31'h0, b256.ReqErr}, 32'h0);
        ResetBar = 1'b1;

        foreach (vecs[i]) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wd, 1'b0, 1'b0, 1'b0,
                lat, rv, wdn, rdat, err, perr, idle);
            chk({vecs[i].name, "_lat"},   lat, vecs[i].lat);
            chk({vecs[i].name, "_rv"},    {31'h0, rv}, {31'h0, vecs[i].rv});
            chk({vecs[i].name, "_wd"},    {31'h0, wdn}, {31'h0, vecs[i].wdn});
            chk({vecs[i].name, "_rdata"}, {24'h0, rdat}, {24'h0, vecs[i].rdata});
            chk({vecs[i].name, "_err"},   {31'h0, err}, {31'h0, vecs[i].err});
            chk({vecs[i].name, "_idle"},  {31'h0, idle}, 32'h0);
        end

        // Abort: reset lands between accept and commit of a write to 8'h20.
        @(negedge Fclk);
        wr = 1'b1; adr = 8'h20; wd = 8'hFF;
        @(negedge Fclk);
        wr = 1'b0;
        chk("abort_busy_pre", {31'h0, b256.Busy}, 32'h1);
        ResetBar = 1'b0;
        #1;
        chk("abort_rdata",  {24'h0, b256.RData}, 32'h00);
        chk("abort_rdval",  {31'h0, b256.RdValid}, 32'h0);
        chk("abort_wrdone", {31'h0, b256.WrDone}, 32'h0);
        chk("abort_busy",   {31'h0, b256.Busy}, 32'h0);
        chk("abort_reqerr", {31'h0, b256.ReqErr}, 32'h0);
        @(negedge Fclk);
        ResetBar = 1'b1;
        txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, lat, rv, wdn, rdat, err, perr, idle);
        chk("abort_rd_lat",   lat, 2);
        chk("abort_rd_rdata", {24'h0, rdat}, 32'h11);
        chk("abort_rd_err",   {31'h0, err}, 32'h0);

        // Overrun: ReadEn pulsed during WAIT of a read of 8'h3C.
        txn(1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, lat, rv, wdn, rdat, err, perr, idle);
        chk("ovr_lat",   lat, 2);
        chk("ovr_rv",    {31'h0, rv}, 32'h1);
        chk("ovr_rdata", {24'h0, rdat}, 32'hA5);
        chk("ovr_err",   {31'h0, err}, 32'h1);
        chk("ovr_idle",  {31'h0, idle}, 32'h0);

`ifdef MEM_PARITY_EN
        txn(1'b0, 1'b1, 8'h30, 8'hC3, 1'b1, 1'b0, 1'b0, lat, rv, wdn, rdat, err, perr, idle);
        txn(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, lat, rv, wdn, rdat, err, perr, idle);
        chk("par_bad_rdata", {24'h0, rdat}, 32'hC3);
        chk("par_bad_err",   {31'h0, perr}, 32'h1);
        txn(1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, lat, rv, wdn, rdat, err, perr, idle);
        chk("par_ok_err",    {31'h0, perr}, 32'h0);
`endif

        // Wrap on the DEPTH=16, WAIT_CYCLES=0 instance.
        repeat (3) @(negedge Fclk);
        txn(1'b0, 1'b1, 8'h05, 8'h77, 1'b0, 1'b0, 1'b1, lat, rv, wdn, rdat, err, perr, idle);
        chk("wrap_wr_lat",  lat, 1);
        chk("wrap_wr_wd",   {31'h0, wdn}, 32'h1);
        chk("wrap_wr_idle", {31'h0, idle}, 32'h0);
        repeat (3) @(negedge Fclk);
        txn(1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 1'b0, 1'b1, lat, rv, wdn, rdat, err, perr, idle);
        chk("wrap_rd_lat",   lat, 1);
        chk("wrap_rd_rv",    {31'h0, rv}, 32'h1);
        chk("wrap_rd_rdata", {24'h0, rdat}, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
